// File: rtl/id_emitter.sv
// id_emitter: emits one identifier (letter first, then alternating digit/letter)
// of len characters followed by the TERM_CHAR terminator, one byte per cycle.
// Optional build macro: ID_UPPER_EN makes the lead character uppercase.
module id_emitter #(
   parameter logic [7:0] TERM_CHAR = 8'd47
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] len,
   input  logic [7:0] seed,
   output logic [7:0] char,
   output logic       valid,
   output logic       busy,
   output logic       done
);

`ifdef ID_UPPER_EN
   localparam logic [7:0] LEAD_BASE = 8'h41;
`else
   localparam logic [7:0] LEAD_BASE = 8'h61;
`endif
   localparam logic [7:0] BODY_BASE  = 8'h61;
   localparam logic [7:0] DIGIT_BASE = 8'h30;

   typedef enum logic [1:0] {IDLE, LEAD, BODY, TERM} state_t;

   state_t     state;
   logic [4:0] l_idx;   // index of the next letter to emit
   logic [3:0] d_idx;   // index of the next digit to emit
   logic [3:0] pos;     // stream position of the byte currently on char
   logic [3:0] last;    // position of the final character (len-1, len=0 as 1)

   logic [4:0] seed_l;
   logic [3:0] nxt_pos;

   // seed letter index reduced mod 26 and next body position
   always_comb begin
      seed_l  = (seed[4:0] >= 5'd26) ? (seed[4:0] - 5'd26) : seed[4:0];
      nxt_pos = pos + 4'd1;
   end

   function automatic logic [4:0] l_inc(input logic [4:0] x);
      return (x == 5'd25) ? 5'd0 : x + 5'd1;
   endfunction

   function automatic logic [3:0] d_inc(input logic [3:0] x);
      return (x == 4'd9) ? 4'd0 : x + 4'd1;
   endfunction

   // single FSM with registered outputs; the state names the byte on char
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         char  <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         l_idx <= '0;
         d_idx <= '0;
         pos   <= '0;
         last  <= '0;
      end else begin
         case (state)
            IDLE: begin
               char  <= '0;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  state <= LEAD;
                  char  <= LEAD_BASE + {3'b000, seed_l};
                  valid <= 1'b1;
                  busy  <= 1'b1;
                  l_idx <= l_inc(seed_l);
                  d_idx <= {1'b0, seed[7:5]};
                  pos   <= '0;
                  last  <= (len == 4'd0) ? 4'd0 : len - 4'd1;
               end
            end
            LEAD: begin
               if (last == 4'd0) begin
                  state <= TERM;
                  char  <= TERM_CHAR;
                  done  <= 1'b1;
               end else begin
                  state <= BODY;
                  pos   <= 4'd1;
                  char  <= DIGIT_BASE + {4'b0000, d_idx};
                  d_idx <= d_inc(d_idx);
               end
            end
            BODY: begin
               if (pos == last) begin
                  state <= TERM;
                  char  <= TERM_CHAR;
                  done  <= 1'b1;
               end else begin
                  pos <= nxt_pos;
                  if (nxt_pos[0]) begin
                     char  <= DIGIT_BASE + {4'b0000, d_idx};
                     d_idx <= d_inc(d_idx);
                  end else begin
                     char  <= BODY_BASE + {3'b000, l_idx};
                     l_idx <= l_inc(l_idx);
                  end
               end
            end
            TERM: begin
               state <= IDLE;
               char  <= '0;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_id_emitter.sv
// tb_id_emitter: directed and randomized identifier streams compared against
// a queue-based reference model computed from the character rules.
module tb_id_emitter;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] len;
   logic [7:0] seed;
   logic [7:0] char;
   logic       valid;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   id_emitter #(.TERM_CHAR(8'd47)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .len   (len),
      .seed  (seed),
      .char  (char),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference: list of bytes the identifier for (seed,len) should produce
   task automatic build_ref(input logic [7:0] s, input logic [3:0] n, output byte q[$]);
      int l, d, cnt;
      q = {};
      l = int'(s[4:0]) % 26;
      d = int'(s[7:5]);
      cnt = (n == 0) ? 1 : int'(n);
      for (int k = 0; k < cnt; k++) begin
         if (k % 2 == 0) begin
`ifdef ID_UPPER_EN
            q.push_back(byte'((k == 0 ? 65 : 97) + l));
`else
            q.push_back(byte'(97 + l));
`endif
            l = (l + 1) % 26;
         end else begin
            q.push_back(byte'(48 + d));
            d = (d + 1) % 10;
         end
      end
      q.push_back(byte'(47));
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".char"},  char,  0);
      check({tag, ".valid"}, valid, 0);
      check({tag, ".busy"},  busy,  0);
      check({tag, ".done"},  done,  0);
   endtask

   // checks the stream, first byte at the next falling edge; with noise,
   // random start requests (and random len/seed) are thrown at the busy DUT
   task automatic expect_stream(input string tag, input logic [7:0] s,
                                input logic [3:0] n, input bit noise);
      byte q[$];
      build_ref(s, n, q);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         check($sformatf("%s.char[%0d]", tag, i), char, q[i]);
         check($sformatf("%s.valid[%0d]", tag, i), valid, 1);
         check($sformatf("%s.busy[%0d]", tag, i), busy, 1);
         check($sformatf("%s.done[%0d]", tag, i), done, (i == q.size() - 1) ? 1 : 0);
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            len   = 4'($urandom);
            seed  = 8'($urandom);
         end
      end
      @(negedge clk);
      start = 1'b0;
      check_idle({tag, ".after"});
   endtask

   task automatic run_id(input string tag, input logic [7:0] s, input logic [3:0] n, input bit noise);
      @(negedge clk);
      start = 1'b1;
      len   = n;
      seed  = s;
      @(posedge clk);
      #1 start = 1'b0;
      len  = 4'($urandom);
      seed = 8'($urandom);
      expect_stream(tag, s, n, noise);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      len   = '0;
      seed  = '0;
      #12;
      check_idle("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

`ifdef ID_UPPER_EN
      run_id("upper", 8'h00, 4'd3, 1'b0);
`endif
      run_id("basic",   8'h00, 4'd4, 1'b0);
      run_id("dwrap",   8'hE3, 4'd9, 1'b0);
      run_id("lwrap",   8'h19, 4'd3, 1'b0);
      run_id("mod26",   8'h1F, 4'd1, 1'b0);
      run_id("len0",    8'h02, 4'd0, 1'b0);
      run_id("len15",   8'h5A, 4'd15, 1'b0);

      // start held high: terminator, one idle cycle, then the next identifier
      @(negedge clk);
      start = 1'b1;
      len   = 4'd0;
      seed  = 8'h02;
      @(posedge clk);
      expect_stream("hold1", 8'h02, 4'd0, 1'b0);
      start = 1'b1;
      expect_stream("hold2", 8'h02, 4'd0, 1'b0);
      start = 1'b1;
      expect_stream("hold3", 8'h02, 4'd0, 1'b0);

      // asynchronous reset during the third byte of a len=6 stream
      @(negedge clk);
      start = 1'b1;
      len   = 4'd6;
      seed  = 8'h00;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("rst_mid.char_before", char, 8'h62);
      #2 reset = 1'b1;
      #1;
      check_idle("rst_mid.async");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("rst_mid.nostream[%0d]", i), {valid, char}, 0);
      end
      run_id("after_rst", 8'h00, 4'd2, 1'b0);

      // randomized identifiers with noise starts and random idle gaps
      for (int t = 0; t < 40; t++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_idle($sformatf("gap%0d", t));
         end
         run_id($sformatf("rnd%0d", t), 8'($urandom), 4'($urandom), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_emitter.md
ID_EMITTER -- requirements
Module: id_emitter

Interface
REQ-001 Parameter: TERM_CHAR, default 8'd47 ('/'), terminator byte emitted after every identifier.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to emit one identifier; sampled only in IDLE.
REQ-005 len  input  4  identifier length in characters, terminator excluded; captured with start.
REQ-006 seed  input  8  character-sequence seed; captured with start.
REQ-007 char  output  8  ASCII byte of the current stream position.
REQ-008 valid  output  1  char holds a stream byte this cycle.
REQ-009 busy  output  1  high from cycle after accepted start through the terminator cycle.
REQ-010 done  output  1  one-cycle pulse coincident with the terminator byte.

Function
REQ-011 All outputs SHALL be registered; char SHALL be 8'd0 whenever valid=0.
REQ-012 FSM states SHALL be IDLE, LEAD, BODY, TERM; IDLE->LEAD on start, LEAD->BODY if captured length>1 else LEAD->TERM, BODY->TERM after its last character, TERM->IDLE unconditionally.
REQ-013 len=0 SHALL be treated as len=1 (lead character only).
REQ-014 start asserted outside IDLE SHALL be ignored; start in the TERM cycle SHALL be ignored; back-to-back start is accepted earliest the cycle after TERM.
REQ-015 Latency: first character SHALL appear (valid=1) in the cycle after the clk edge sampling start; one byte per cycle, no gaps, len+1 bytes total.
REQ-016 On start, letter index L SHALL load seed[4:0] reduced mod 26 (subtract 26 if >=26), digit index D SHALL load seed[7:5].
REQ-017 Position k=0 (LEAD) SHALL emit 'a'+L; even k>0 SHALL emit 'a'+L; odd k SHALL emit '0'+D.
REQ-018 After each letter L SHALL increment, wrapping 25->0; after each digit D SHALL increment, wrapping 9->0.
REQ-019 TERM SHALL emit TERM_CHAR with valid=1, done=1, busy=1.
REQ-020 Position counter SHALL be 4 bits; len=15 SHALL yield 15 characters plus terminator without overflow.
REQ-021 The emitted stream SHALL always be a lexically valid identifier (letter first, then letters/digits) followed by a non-alphanumeric terminator.

Reset
REQ-022 reset SHALL force IDLE immediately, regardless of clk, with char=0, valid=0, busy=0, done=0, L=0, D=0.
REQ-023 reset mid-identifier SHALL abort the stream without emitting the terminator; next start after release SHALL behave as from power-up.

Configuration
REQ-024 Macro ID_UPPER_EN: when defined, the k=0 lead character SHALL be 'A'+L (uppercase); when undefined, lead SHALL be 'a'+L; body characters are lowercase in both builds.

Verification
REQ-025 seed=8'h00, len=4, start one cycle -> bytes 'a','0','b','1','/' on consecutive cycles, done only on '/', busy high 5 cycles.
REQ-026 seed=8'hE3, len=9 -> 'd','7','e','8','f','9','g','0','h','/' (digit wrap 9->0).
REQ-027 seed=8'h19, len=3 -> 'z','0','a','/' (letter wrap); seed=8'h1F, len=1 -> 'f','/' (mod-26 reduction).
REQ-028 len=0, seed=8'h02 -> 'c','/'; start held high throughout -> next identifier begins cycle after '/', none restarted mid-stream.
REQ-029 reset asserted asynchronously during third byte of len=6 stream -> outputs 0 within same cycle, no '/' emitted; subsequent start seed=8'h00, len=2 -> 'a','0','/'.
REQ-030 Build with ID_UPPER_EN, seed=8'h00, len=3 -> 'A','0','b','/'.
